// File: rtl/prbs_pkg.sv
// Shared definitions for the Galois-LFSR PRBS generator/checker pair.
// The state enum and the LFSR step function are used by both sides.
package prbs_pkg;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} prbs_state_e;

    // The step function works on a fixed 64-bit word.
    // Callers zero-extend narrower states and masks, then truncate the result.
    localparam int unsigned LFSR_MAX_W = 64;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] x,
        input logic [LFSR_MAX_W-1:0] fb
    );
        return x[0] ? ((x >> 1) ^ fb) : (x >> 1);
    endfunction

endpackage

// File: rtl/prbs_popcount.sv
// Combinational population count of an N-bit word.
// The checker uses it to count bit errors.
module prbs_popcount #(
    parameter int unsigned N = 8,
    localparam int unsigned PW = $clog2(N + 1)
) (
    input  logic [N-1:0]  data_i,
    output logic [PW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            count_o = count_o + PW'(data_i[i]);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker with lock tracking and a saturating error count.
// Define PRBS_CHK_BITERR_EN to count bit errors instead of word errors.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter logic [N-1:0] FB      = 8'h8e,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [N-1:0]  din,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] err_cnt
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

    prbs_state_e        state_q;
    logic [N-1:0]       exp_q;
    logic [MATCH_W-1:0] match_q;
    logic [MISS_W-1:0]  miss_q;
    logic               locked_q;
    logic               err_q;
    logic [CW-1:0]      err_cnt_q;

    logic [N-1:0]       din_next_d;
    logic [N-1:0]       exp_next_d;
    logic               mismatch_d;

    assign din_next_d = N'(lfsr_next(LFSR_MAX_W'(din), LFSR_MAX_W'(FB)));
    assign exp_next_d = N'(lfsr_next(LFSR_MAX_W'(exp_q), LFSR_MAX_W'(FB)));
    assign mismatch_d = (din != exp_q);

`ifdef PRBS_CHK_BITERR_EN
    localparam int unsigned PW = $clog2(N + 1);
    logic [PW-1:0] inc_d;

    prbs_popcount #(.N(N)) u_popcount (
        .data_i  (din ^ exp_q),
        .count_o (inc_d)
    );
`else
    localparam int unsigned PW = 1;
    logic [PW-1:0] inc_d;

    assign inc_d = 1'b1;
`endif

    // One spare bit above the wider operand catches overflow for the saturation test.
    localparam int unsigned SW = ((CW > PW) ? CW : PW) + 1;

    logic [SW-1:0] sum_d;
    logic [CW-1:0] err_cnt_sat_d;

    assign sum_d         = SW'(err_cnt_q) + SW'(inc_d);
    assign err_cnt_sat_d = (sum_d > SW'({CW{1'b1}})) ? '1 : sum_d[CW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            exp_q     <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (en) begin
                unique case (state_q)
                    HUNT: begin
                        // An all-zero word is the LFSR lockup state and cannot seed.
                        if (din != '0) begin
                            exp_q   <= din_next_d;
                            match_q <= '0;
                            state_q <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        exp_q <= din_next_d;
                        if (!mismatch_d) begin
                            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                match_q  <= '0;
                                miss_q   <= '0;
                            end else begin
                                match_q <= match_q + MATCH_W'(1);
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel on the prediction so a corrupted word never re-seeds it.
                        exp_q <= exp_next_d;
                        if (!mismatch_d) begin
                            miss_q <= '0;
                        end else begin
                            err_q <= 1'b1;
                            if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                                miss_q   <= '0;
                            end else begin
                                miss_q <= miss_q + MISS_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end

            if (clr) begin
                err_cnt_q <= '0;
            end else if (en && (state_q == LOCKED) && mismatch_d) begin
                err_cnt_q <= err_cnt_sat_d;
            end
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule
